// File: rtl/rob_commit_queue_if.sv
// rtl/rob_commit_queue_if.sv - dispatcher/CDB/commit bundle of the reorder buffer
interface rob_commit_queue_if #(
    parameter int ROB_ID_W = 5
);
    logic                alloc_valid_in;
    logic [4:0]          alloc_rd_in;
    logic                alloc_is_br_in;
    logic                alloc_pred_in;
    logic [31:0]         alloc_pc_in;
    logic [ROB_ID_W-1:0] alloc_id_out;
    logic                full_out;
    logic                rdy_in;

    logic                wb_valid_in;
    logic [ROB_ID_W-1:0] wb_id_in;
    logic [31:0]         wb_value_in;
    logic                wb_taken_in;
    logic [31:0]         wb_target_in;

    logic [ROB_ID_W-1:0] query1_id_in;
    logic                ready1_out;
    logic [31:0]         value1_out;
    logic [ROB_ID_W-1:0] query2_id_in;
    logic                ready2_out;
    logic [31:0]         value2_out;

    logic                commit_flag_out;
    logic [4:0]          rd_out;
    logic [31:0]         V_out;
    logic [ROB_ID_W-1:0] Q_out;
    logic [31:0]         commit_pc_out;
    logic                rollback_flag_out;
    logic [31:0]         redirect_pc_out;

    modport master (
        output alloc_valid_in, alloc_rd_in, alloc_is_br_in, alloc_pred_in, alloc_pc_in, rdy_in,
        output wb_valid_in, wb_id_in, wb_value_in, wb_taken_in, wb_target_in,
        output query1_id_in, query2_id_in,
        input  alloc_id_out, full_out, ready1_out, value1_out, ready2_out, value2_out,
        input  commit_flag_out, rd_out, V_out, Q_out, commit_pc_out,
        input  rollback_flag_out, redirect_pc_out
    );

    modport slave (
        input  alloc_valid_in, alloc_rd_in, alloc_is_br_in, alloc_pred_in, alloc_pc_in, rdy_in,
        input  wb_valid_in, wb_id_in, wb_value_in, wb_taken_in, wb_target_in,
        input  query1_id_in, query2_id_in,
        output alloc_id_out, full_out, ready1_out, value1_out, ready2_out, value2_out,
        output commit_flag_out, rd_out, V_out, Q_out, commit_pc_out,
        output rollback_flag_out, redirect_pc_out
    );
endinterface

// File: rtl/rob_commit_queue.sv
// rtl/rob_commit_queue.sv - in-order reorder buffer with CDB fill, operand lookup and commit/rollback
module rob_commit_queue #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_ID_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    rob_commit_queue_if.slave bus
);
    localparam int IDX_W = ROB_ID_W - 1;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [ROB_ID_W-1:0] tag_t;

    localparam tag_t DEPTH_TAG = tag_t'(ROB_DEPTH);

    // Per-slot control bits live in packed vectors so next-state can be built combinationally.
    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;
    logic [ROB_DEPTH-1:0] is_br_q, is_br_d;
    logic [ROB_DEPTH-1:0] pred_q, pred_d;
    logic [ROB_DEPTH-1:0] taken_q, taken_d;

    logic [4:0]  rd_mem_q     [ROB_DEPTH];
    logic [31:0] pc_mem_q     [ROB_DEPTH];
    logic [31:0] value_mem_q  [ROB_DEPTH];
    logic [31:0] target_mem_q [ROB_DEPTH];

    idx_t head_q, head_d;
    idx_t tail_q, tail_d;
    tag_t count_q, count_d;

    logic        commit_flag_q, commit_flag_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [31:0] v_out_q, v_out_d;
    tag_t        q_out_q, q_out_d;
    logic [31:0] commit_pc_q, commit_pc_d;
    logic        rollback_q, rollback_d;
    logic [31:0] redirect_q, redirect_d;

    logic full;
    logic wb_tag_ok;
    idx_t wb_idx;
    logic wb_hit;
    logic commit_ok;
    logic mispredict;
    logic alloc_ok;
    logic wb_ok;

    assign full      = (count_q == DEPTH_TAG);
    assign wb_tag_ok = (bus.wb_id_in != '0) && (bus.wb_id_in <= DEPTH_TAG);
    assign wb_idx    = idx_t'(bus.wb_id_in - tag_t'(1));
    assign wb_hit    = bus.wb_valid_in && wb_tag_ok && busy_q[wb_idx];

    assign commit_ok  = bus.rdy_in && (count_q != '0) && busy_q[head_q] && ready_q[head_q];
    assign mispredict = commit_ok && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    // The flush on a mispredict edge wins over anything younger arriving on that same edge.
    assign alloc_ok   = bus.rdy_in && bus.alloc_valid_in && !full && !mispredict;
    assign wb_ok      = bus.rdy_in && wb_hit && !mispredict;

    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        is_br_d       = is_br_q;
        pred_d        = pred_q;
        taken_d       = taken_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_flag_d = 1'b0;
        rollback_d    = 1'b0;
        rd_out_d      = rd_out_q;
        v_out_d       = v_out_q;
        q_out_d       = q_out_q;
        commit_pc_d   = commit_pc_q;
        redirect_d    = redirect_q;

        if (alloc_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            is_br_d[tail_q] = bus.alloc_is_br_in;
            pred_d[tail_q]  = bus.alloc_pred_in;
            tail_d          = tail_q + 1'b1;
        end

        if (wb_ok) begin
            ready_d[wb_idx] = 1'b1;
            taken_d[wb_idx] = bus.wb_taken_in;
        end

        if (commit_ok) begin
            commit_flag_d  = 1'b1;
            rd_out_d       = is_br_q[head_q] ? 5'd0 : rd_mem_q[head_q];
            v_out_d        = value_mem_q[head_q];
            q_out_d        = tag_t'(head_q) + tag_t'(1);
            commit_pc_d    = pc_mem_q[head_q];
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end

        count_d = count_q + tag_t'(alloc_ok) - tag_t'(commit_ok);

        if (mispredict) begin
            rollback_d = 1'b1;
            redirect_d = taken_q[head_q] ? target_mem_q[head_q] : (pc_mem_q[head_q] + 32'd4);
            busy_d     = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q        <= '0;
            ready_q       <= '0;
            is_br_q       <= '0;
            pred_q        <= '0;
            taken_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_flag_q <= 1'b0;
            rd_out_q      <= '0;
            v_out_q       <= '0;
            q_out_q       <= '0;
            commit_pc_q   <= '0;
            rollback_q    <= 1'b0;
            redirect_q    <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            is_br_q       <= is_br_d;
            pred_q        <= pred_d;
            taken_q       <= taken_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_flag_q <= commit_flag_d;
            rd_out_q      <= rd_out_d;
            v_out_q       <= v_out_d;
            q_out_q       <= q_out_d;
            commit_pc_q   <= commit_pc_d;
            rollback_q    <= rollback_d;
            redirect_q    <= redirect_d;
        end
    end

    // Payload storage needs no reset: busy/ready gate every read that matters.
    always_ff @(posedge clk_in) begin
        if (alloc_ok) begin
            rd_mem_q[tail_q] <= bus.alloc_rd_in;
            pc_mem_q[tail_q] <= bus.alloc_pc_in;
        end
        if (wb_ok) begin
            value_mem_q[wb_idx]  <= bus.wb_value_in;
            target_mem_q[wb_idx] <= bus.wb_target_in;
        end
    end

    tag_t        q_id  [2];
    logic        q_rdy [2];
    logic [31:0] q_val [2];

    assign q_id[0] = bus.query1_id_in;
    assign q_id[1] = bus.query2_id_in;

    // A same-cycle CDB hit bypasses storage so dispatch never misses a result in flight.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            q_rdy[k] = 1'b0;
            q_val[k] = '0;
            if ((q_id[k] != '0) && (q_id[k] <= DEPTH_TAG)) begin
                if (wb_hit && (bus.wb_id_in == q_id[k])) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = bus.wb_value_in;
                end else if (ready_q[idx_t'(q_id[k] - tag_t'(1))]) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = value_mem_q[idx_t'(q_id[k] - tag_t'(1))];
                end
            end
        end
    end

    assign bus.ready1_out = q_rdy[0];
    assign bus.value1_out = q_val[0];
    assign bus.ready2_out = q_rdy[1];
    assign bus.value2_out = q_val[1];

    assign bus.alloc_id_out      = tag_t'(tail_q) + tag_t'(1);
    assign bus.full_out          = full;
    assign bus.commit_flag_out   = commit_flag_q;
    assign bus.rd_out            = rd_out_q;
    assign bus.V_out             = v_out_q;
    assign bus.Q_out             = q_out_q;
    assign bus.commit_pc_out     = commit_pc_q;
    assign bus.rollback_flag_out = rollback_q;
    assign bus.redirect_pc_out   = redirect_q;
endmodule

// File: tb/tb_rob_commit_queue.sv
// tb/tb_rob_commit_queue.sv - scoreboard bench for rob_commit_queue
module tb_rob_commit_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_queue_if #(.ROB_ID_W(5)) bus ();

    rob_commit_queue #(.ROB_DEPTH(16), .ROB_ID_W(5)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] v;
        logic [4:0]  q;
        logic [31:0] pc;
        logic        rb;
        logic [31:0] redir;
    } exp_t;

    exp_t        exp_q[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          m_tail = 0;
    logic [31:0] val_of [1:16];
    logic        tk_of  [1:16];
    logic [31:0] tg_of  [1:16];

    // Scoreboard: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.commit_flag_out) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit: got Q=%0d, required no commit", bus.Q_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({bus.rd_out, bus.V_out, bus.Q_out, bus.commit_pc_out, bus.rollback_flag_out} !==
                    {e.rd, e.v, e.q, e.pc, e.rb} || (e.rb && bus.redirect_pc_out !== e.redir)) begin
                    n_fail++;
                    $display("FAIL commit_data: got rd=%0d V=%h Q=%0d pc=%h rb=%0b redir=%h, required rd=%0d V=%h Q=%0d pc=%h rb=%0b redir=%h",
                             bus.rd_out, bus.V_out, bus.Q_out, bus.commit_pc_out, bus.rollback_flag_out,
                             bus.redirect_pc_out, e.rd, e.v, e.q, e.pc, e.rb, e.redir);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rdy_in = 1'b1;
        bus.alloc_valid_in = 1'b0; bus.alloc_rd_in = '0; bus.alloc_is_br_in = 1'b0;
        bus.alloc_pred_in = 1'b0;  bus.alloc_pc_in = '0;
        bus.wb_valid_in = 1'b0; bus.wb_id_in = '0; bus.wb_value_in = '0;
        bus.wb_taken_in = 1'b0; bus.wb_target_in = '0;
        bus.query1_id_in = '0; bus.query2_id_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        exp_q.delete();
        m_tail = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [31:0] pc, input logic br, input logic pred,
                            input logic [31:0] val, input logic taken, input logic [31:0] target,
                            input bit push);
        exp_t e;
        int   tag;
        tag = m_tail + 1;
        val_of[tag] = val; tk_of[tag] = taken; tg_of[tag] = target;
        e.rd = br ? 5'd0 : rd;
        e.v = val;
        e.q = 5'(tag);
        e.pc = pc;
        e.rb = br && (taken != pred);
        e.redir = taken ? target : pc + 32'd4;
        if (push) exp_q.push_back(e);
        m_tail = (m_tail + 1) % 16;
        bus.alloc_valid_in = 1'b1; bus.alloc_rd_in = rd; bus.alloc_pc_in = pc;
        bus.alloc_is_br_in = br;   bus.alloc_pred_in = pred;
        tick();
        bus.alloc_valid_in = 1'b0;
    endtask

    task automatic do_wb(input int tag);
        bus.wb_valid_in = 1'b1; bus.wb_id_in = 5'(tag); bus.wb_value_in = val_of[tag];
        bus.wb_taken_in = tk_of[tag]; bus.wb_target_in = tg_of[tag];
        tick();
        bus.wb_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_run++;
        if ({bus.commit_flag_out, bus.rollback_flag_out, bus.full_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000",
                     {bus.commit_flag_out, bus.rollback_flag_out, bus.full_out});
        end
        n_run++;
        if ({bus.rd_out, bus.V_out, bus.Q_out, bus.commit_pc_out, bus.redirect_pc_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rd=%0d V=%h Q=%0d pc=%h redir=%h, required all 0",
                     bus.rd_out, bus.V_out, bus.Q_out, bus.commit_pc_out, bus.redirect_pc_out);
        end
        n_run++;
        if (bus.alloc_id_out !== 5'd1) begin
            n_fail++;
            $display("FAIL reset_alloc_id: got %0d, required 1", bus.alloc_id_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_commit();
        do_reset();
        do_alloc(5'd5, 32'h100, 1'b0, 1'b0, 32'hDEAD, 1'b0, 32'h0, 1'b1);
        do_wb(1);
        n_run++;
        if (bus.commit_flag_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got commit_flag=%b, required 0", bus.commit_flag_out);
        end
        tick();
        n_run++;
        if (bus.commit_flag_out !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_commit: got commit_flag=%b, required 1", bus.commit_flag_out);
        end
        tick();
        n_run++;
        if (bus.commit_flag_out !== 1'b0 || bus.alloc_id_out !== 5'd2) begin
            n_fail++;
            $display("FAIL basic_after: got flag=%b alloc_id=%0d, required flag=0 alloc_id=2",
                     bus.commit_flag_out, bus.alloc_id_out);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++)
            do_alloc(5'(i + 1), 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
        n_run++;
        if (bus.full_out !== 1'b1 || bus.alloc_id_out !== 5'd1) begin
            n_fail++;
            $display("FAIL full_set: got full=%b alloc_id=%0d, required full=1 alloc_id=1",
                     bus.full_out, bus.alloc_id_out);
        end
        bus.alloc_valid_in = 1'b1; bus.alloc_rd_in = 5'd31; bus.alloc_pc_in = 32'hBAD0;
        tick();
        bus.alloc_valid_in = 1'b0;
        n_run++;
        if (bus.full_out !== 1'b1 || bus.alloc_id_out !== 5'd1) begin
            n_fail++;
            $display("FAIL full_ignore: got full=%b alloc_id=%0d, required full=1 alloc_id=1",
                     bus.full_out, bus.alloc_id_out);
        end
        do_wb(1);
        tick();
        n_run++;
        if (bus.full_out !== 1'b0 || bus.alloc_id_out !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap_free: got full=%b alloc_id=%0d, required full=0 alloc_id=1",
                     bus.full_out, bus.alloc_id_out);
        end
        do_alloc(5'd9, 32'h2000, 1'b0, 1'b0, 32'hC0DE_0001, 1'b0, 32'h0, 1'b1);
        n_run++;
        if (bus.full_out !== 1'b1 || bus.alloc_id_out !== 5'd2) begin
            n_fail++;
            $display("FAIL wrap_alloc: got full=%b alloc_id=%0d, required full=1 alloc_id=2",
                     bus.full_out, bus.alloc_id_out);
        end
        for (int t = 2; t <= 16; t++) do_wb(t);
        do_wb(1);
        wait_drain(40);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain: got %0d pending commits, required 0", exp_q.size());
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 1; i <= 3; i++)
            do_alloc(5'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0, 32'h5000 + 32'(i), 1'b0, 32'h0, 1'b1);
        do_wb(3);
        do_wb(2);
        n_run++;
        if (bus.commit_flag_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_hold: got commit_flag=%b, required 0", bus.commit_flag_out);
        end
        do_wb(1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_run++;
            if (bus.commit_flag_out !== 1'b1 || bus.Q_out !== 5'(c)) begin
                n_fail++;
                $display("FAIL ooo_order: got flag=%b Q=%0d, required flag=1 Q=%0d",
                         bus.commit_flag_out, bus.Q_out, c);
            end
        end
        tick();
    endtask

    task automatic test_mispredict();
        do_reset();
        do_alloc(5'd7, 32'h200, 1'b1, 1'b0, 32'h55, 1'b1, 32'h300, 1'b1);
        do_alloc(5'd9, 32'h204, 1'b0, 1'b0, 32'h99, 1'b0, 32'h0, 1'b0);
        do_alloc(5'd10, 32'h208, 1'b0, 1'b0, 32'hAA, 1'b0, 32'h0, 1'b0);
        do_wb(2);
        do_wb(3);
        do_wb(1);
        bus.alloc_valid_in = 1'b1; bus.alloc_rd_in = 5'd3; bus.alloc_pc_in = 32'h999;
        tick();
        bus.alloc_valid_in = 1'b0;
        n_run++;
        if (bus.rollback_flag_out !== 1'b1 || bus.redirect_pc_out !== 32'h300) begin
            n_fail++;
            $display("FAIL mispredict_flag: got rb=%b redir=%h, required rb=1 redir=00000300",
                     bus.rollback_flag_out, bus.redirect_pc_out);
        end
        n_run++;
        if (bus.alloc_id_out !== 5'd1 || bus.full_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mispredict_flush: got alloc_id=%0d full=%b, required alloc_id=1 full=0",
                     bus.alloc_id_out, bus.full_out);
        end
        m_tail = 0;
        tick();
        n_run++;
        if (bus.rollback_flag_out !== 1'b0 || bus.commit_flag_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mispredict_pulse: got rb=%b flag=%b, required 0 0",
                     bus.rollback_flag_out, bus.commit_flag_out);
        end
        repeat (3) tick();
        do_alloc(5'd4, 32'h400, 1'b1, 1'b1, 32'h11, 1'b1, 32'h500, 1'b1);
        do_alloc(5'd6, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h22, 1'b0, 32'h700, 1'b1);
        do_wb(1);
        do_wb(2);
        wait_drain(10);
        n_run++;
        if (bus.redirect_pc_out !== 32'h0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mispredict_wrap: got redir=%h pending=%0d, required redir=00000000 pending=0",
                     bus.redirect_pc_out, exp_q.size());
        end
    endtask

    task automatic test_query_bypass();
        do_reset();
        do_alloc(5'd1, 32'h600, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0, 1'b1);
        do_alloc(5'd2, 32'h604, 1'b0, 1'b0, 32'h7, 1'b0, 32'h0, 1'b1);
        bus.query1_id_in = 5'd2; bus.query2_id_in = 5'd1;
        bus.wb_valid_in = 1'b1; bus.wb_id_in = 5'd2; bus.wb_value_in = 32'h7;
        #1;
        n_run++;
        if (bus.ready1_out !== 1'b1 || bus.value1_out !== 32'h7 || bus.ready2_out !== 1'b0) begin
            n_fail++;
            $display("FAIL query_bypass: got r1=%b v1=%h r2=%b, required r1=1 v1=00000007 r2=0",
                     bus.ready1_out, bus.value1_out, bus.ready2_out);
        end
        tick();
        bus.wb_valid_in = 1'b0;
        #1;
        n_run++;
        if (bus.ready1_out !== 1'b1 || bus.value1_out !== 32'h7) begin
            n_fail++;
            $display("FAIL query_stored: got r1=%b v1=%h, required r1=1 v1=00000007",
                     bus.ready1_out, bus.value1_out);
        end
        bus.query1_id_in = 5'd0;
        #1;
        n_run++;
        if (bus.ready1_out !== 1'b0 || bus.value1_out !== 32'h0) begin
            n_fail++;
            $display("FAIL query_tag0: got r1=%b v1=%h, required r1=0 v1=0", bus.ready1_out, bus.value1_out);
        end
        bus.query2_id_in = 5'd0;
        do_wb(1);
        wait_drain(10);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL query_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        do_alloc(5'd12, 32'h800, 1'b0, 1'b0, 32'h77, 1'b0, 32'h0, 1'b1);
        do_wb(1);
        bus.rdy_in = 1'b0;
        bus.alloc_valid_in = 1'b1; bus.alloc_rd_in = 5'd13; bus.alloc_pc_in = 32'h804;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (bus.commit_flag_out !== 1'b0 || bus.alloc_id_out !== 5'd2) begin
                n_fail++;
                $display("FAIL freeze: got flag=%b alloc_id=%0d, required flag=0 alloc_id=2",
                         bus.commit_flag_out, bus.alloc_id_out);
            end
        end
        bus.alloc_valid_in = 1'b0;
        bus.rdy_in = 1'b1;
        tick();
        n_run++;
        if (bus.commit_flag_out !== 1'b1 || bus.V_out !== 32'h77) begin
            n_fail++;
            $display("FAIL unfreeze: got flag=%b V=%h, required flag=1 V=00000077",
                     bus.commit_flag_out, bus.V_out);
        end
        do_alloc(5'd14, 32'h808, 1'b0, 1'b0, 32'h88, 1'b0, 32'h0, 1'b0);
        do_wb(2);
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({bus.commit_flag_out, bus.rollback_flag_out, bus.full_out, bus.rd_out, bus.V_out, bus.Q_out} !== '0 ||
            bus.alloc_id_out !== 5'd1) begin
            n_fail++;
            $display("FAIL async_reset: got flag=%b rd=%0d V=%h Q=%0d alloc_id=%0d, required all 0 alloc_id=1",
                     bus.commit_flag_out, bus.rd_out, bus.V_out, bus.Q_out, bus.alloc_id_out);
        end
        tick();
        tick();
        n_run++;
        if (bus.commit_flag_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got flag=%b, required 0", bus.commit_flag_out);
        end
        rst_n = 1'b1;
        exp_q.delete();
        m_tail = 0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_out_of_order();
        test_mispredict();
        test_query_bypass();
        test_freeze_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
